bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Loadable, synchronous two-digit BCD down-counter (99..00) with start/pause control and a one-cycle terminal-count pulse. It is the counting-down counterpart of the team's BCD decade up-counters and serves as the countdown timer for the lab display datapath. Both digits change on the same `clk` edge; there is no digit-to-digit ripple clocking. Each digit is individually sanitized on load, so `count` is always valid BCD.

## Interface
- `TICK_DIV`, default 1: number of `clk` cycles per decrement while running; legal range ≥ 1.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  synchronous load strobe for `load_val`.
- `load_val`  input  8  preset value: [7:4] tens digit, [3:0] units digit.
- `start`  input  1  start or resume counting.
- `pause`  input  1  suspend counting and keep the current value.
- `count`  output  8  current value: [7:4] tens digit, [3:0] units digit; always valid BCD.
- `running`  output  1  high while in state RUN.
- `done`  output  1  one-cycle pulse when the count reaches 00 from a decrement.
- `zero`  output  1  combinational, high when `count == 8'h00`.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset values: state IDLE, `count` 8'h00, prescaler 0, `running` 0, `done` 0, `zero` 1.
- Control priority each edge: `load` first, then `pause`, then `start`.
- `load` in any state:
  - Each nibble of `load_val` greater than 9 is clamped to 9, so 8'hA5 loads 95 and 8'hFF loads 99.
  - `count` takes the clamped value; state goes to IDLE; prescaler clears to 0.
- `start` in IDLE or HOLD with `count` ≠ 00: go to RUN.
  - From IDLE, the prescaler starts from 0.
  - From HOLD, the prescaler keeps the value it had at pause.
- `start` with `count` = 00 is ignored; state stays IDLE.
- `pause` in RUN: go to HOLD; `count` and prescaler frozen.
- `pause` in any other state is ignored.
- `start` in RUN or DONE is ignored.
- RUN behaviour:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - A decrement occurs on each edge where the prescaler wraps.
  - With TICK_DIV = 1, a decrement occurs on every edge.
- Decrement rule:
  - Units digit ≠ 0: units − 1.
  - Units digit = 0: units = 9 and tens − 1.
- Decrement from 01 to 00: state goes to DONE on that edge, and `done` is registered high on that same edge.
- DONE: `done` is high for exactly one cycle; the next edge goes to IDLE with `done` = 0 and `count` held at 00.
- `load` while in DONE goes to IDLE with the new value; `done` still drops after its single cycle.
- `running` = (state == RUN), registered.

## Timing
- `start` sampled at edge E0 (IDLE, prescaler 0): `running` is high after E0.
- Decrements occur at edges E0 + k·TICK_DIV, for k = 1..N, where N is the starting value in decimal.
- Counting from N to 00 takes N·TICK_DIV cycles after E0.
- Example, TICK_DIV = 1, start from 03 at E0:
  - After E1: 02. After E2: 01. After E3: 00, with `done` = 1 and `running` = 0.
  - After E4: IDLE, `done` = 0.
- `load` takes effect at the sampling edge; `count` shows the new value in the following cycle.
- Pause at edge Ep: no decrement at Ep or at any later edge until resume.
  - Resume at edge Er: the prescaler continues from its saved value starting at Er.
  - Total RUN edges to reach 00 are unchanged by the pause.
- Assertion of `reset` in any state, including mid-RUN or during DONE:
  - Outputs take their reset values immediately, without waiting for `clk`.
  - A `done` pulse in progress is cut off.
- Wrap-around never occurs: the counter stops at 00 and never goes 00 → 99.

## Test plan
- Reset then load 8'h12, TICK_DIV=1, start -> `count` goes 12, 11, 10, 09, …, 01, 00 on consecutive edges; `done` high exactly one cycle with `count`=00; `running` 0 afterward.
- Load 8'hAF -> `count`=8'h99; start and run 100 edges -> `done` pulse once, and `count` is never non-BCD.
- TICK_DIV=4, load 8'h02, start at E0 -> `count` is 01 after E4 and 00 after E8 with `done`=1; `done` low at every other edge.
- TICK_DIV=3, load 8'h05, start, pause after 4 edges, wait 10 cycles, start -> `count` frozen at 04 during the pause; 00 is reached exactly 15 RUN edges after the first start.
- Load 8'h00 then start -> state stays IDLE, `running`=0, `done`=0, `zero`=1; also assert `load` and `pause` together in RUN -> load wins and the state is IDLE.
- Start from 50 and assert `reset` asynchronously mid-RUN, between clock edges -> `count`=00, `running`=0 and `done`=0 before the next `clk` edge; start after release is ignored.

Source files
------------

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for bcd_countdown_timer.
// The master side drives load/start/pause and observes the count and status flags.
interface bcd_countdown_timer_if;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       zero;

    modport master (
        output load, load_val, start, pause,
        input  count, running, done, zero
    );

    modport slave (
        input  load, load_val, start, pause,
        output count, running, done, zero
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Loadable two-digit BCD down-counter (99..00) with start/pause control,
// a programmable decrement prescaler and a one-cycle terminal-count pulse.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    bcd_countdown_timer_if.slave   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e          state_q;
    logic [7:0]      count_q;
    logic [PW-1:0]   presc_q;
    logic            running_q;
    logic            done_q;

    logic [7:0]      load_clamped_d;
    logic [7:0]      count_dec_d;

    function automatic logic [3:0] clamp9(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    // Both digits update in the same cycle; a units borrow wraps units to 9.
    always_comb begin
        load_clamped_d = {clamp9(bus.load_val[7:4]), clamp9(bus.load_val[3:0])};
        if (count_q[3:0] != 4'd0) begin
            count_dec_d = {count_q[7:4], count_q[3:0] - 4'd1};
        end else begin
            count_dec_d = {count_q[7:4] - 4'd1, 4'd9};
        end
    end

    // NOTE: every register here is assigned with <= so all state advances on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 8'h00;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                count_q   <= load_clamped_d;
                state_q   <= IDLE;
                presc_q   <= '0;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start && (count_q != 8'h00)) begin
                            state_q   <= RUN;
                            presc_q   <= '0;
                            running_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        // Resume keeps the saved prescaler phase.
                        if (bus.start && (count_q != 8'h00)) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state_q   <= HOLD;
                            running_q <= 1'b0;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            count_q <= count_dec_d;
                            if (count_q == 8'h01) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.zero    = (count_q == 8'h00);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: three timers (TICK_DIV 1, 3, 4) share one stimulus stream
// and are compared every cycle against a tick-counting decimal reference model.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;

    bcd_countdown_timer_if ifc0 ();
    bcd_countdown_timer_if ifc1 ();
    bcd_countdown_timer_if ifc2 ();

    assign ifc0.load = load;  assign ifc0.load_val = load_val;
    assign ifc0.start = start; assign ifc0.pause = pause;
    assign ifc1.load = load;  assign ifc1.load_val = load_val;
    assign ifc1.start = start; assign ifc1.pause = pause;
    assign ifc2.load = load;  assign ifc2.load_val = load_val;
    assign ifc2.start = start; assign ifc2.pause = pause;

    bcd_countdown_timer #(.TICK_DIV(1)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
    bcd_countdown_timer #(.TICK_DIV(3)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));
    bcd_countdown_timer #(.TICK_DIV(4)) dut2 (.clk(clk), .reset(reset), .bus(ifc2));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the displayed value is the starting value minus the number
    // of whole TICK_DIV periods spent running, in plain decimal.
    typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mstate_e;
    mstate_e ms     [3];
    int      mstart [3];
    int      mticks [3];
    bit      mdone  [3];
    int      tdiv   [3] = '{1, 3, 4};

    logic [7:0] oc   [3];
    logic       orun [3];
    logic       odn  [3];
    logic       oz   [3];

    function automatic int mval(input int i);
        return mstart[i] - mticks[i] / tdiv[i];
    endfunction

    function automatic int clamp_dec(input logic [7:0] v);
        int tens;
        int units;
        tens  = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        units = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return tens * 10 + units;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ms[i] = M_IDLE; mstart[i] = 0; mticks[i] = 0; mdone[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            mdone[i] = 1'b0;
            if (load) begin
                ms[i] = M_IDLE; mstart[i] = clamp_dec(load_val); mticks[i] = 0;
            end else begin
                case (ms[i])
                    M_IDLE: if (start && mval(i) != 0) begin
                        mstart[i] = mval(i); mticks[i] = 0; ms[i] = M_RUN;
                    end
                    M_HOLD: if (start) ms[i] = M_RUN;
                    M_RUN: begin
                        if (pause) begin
                            ms[i] = M_HOLD;
                        end else begin
                            mticks[i]++;
                            if (mval(i) == 0) begin
                                ms[i] = M_DONE; mdone[i] = 1'b1;
                            end
                        end
                    end
                    M_DONE: begin
                        ms[i] = M_IDLE; mstart[i] = 0; mticks[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic sample();
        oc[0] = ifc0.count; orun[0] = ifc0.running; odn[0] = ifc0.done; oz[0] = ifc0.zero;
        oc[1] = ifc1.count; orun[1] = ifc1.running; odn[1] = ifc1.done; oz[1] = ifc1.zero;
        oc[2] = ifc2.count; orun[2] = ifc2.running; odn[2] = ifc2.done; oz[2] = ifc2.zero;
    endtask

    task automatic check_all();
        int v;
        logic [7:0] exp_count;
        sample();
        for (int i = 0; i < 3; i++) begin
            v = mval(i);
            exp_count = 8'(((v / 10) << 4) | (v % 10));
            check($sformatf("count%0d", i), oc[i], exp_count);
            check($sformatf("running%0d", i), 8'(orun[i]), 8'(ms[i] == M_RUN));
            check($sformatf("done%0d", i), 8'(odn[i]), 8'(mdone[i]));
            check($sformatf("zero%0d", i), 8'(oz[i]), 8'(v == 0));
            check($sformatf("bcd%0d", i), 8'((oc[i][7:4] <= 4'd9) && (oc[i][3:0] <= 4'd9)), 8'd1);
        end
    endtask

    task automatic step(input logic ld, input logic [7:0] lv, input logic st, input logic pa);
        load = ld; load_val = lv; start = st; pause = pa;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Load 12 and count down on every edge (TICK_DIV 1), slower ones follow.
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (k == 12) begin
                check("t1_done_at_00", 8'(odn[0]), 8'd1);
                check("t1_count_00", oc[0], 8'h00);
            end
        end

        // Nibble clamping: AF loads 99, then a full countdown.
        step(1'b1, 8'hAF, 1'b0, 1'b0);
        check("clamp_af", oc[0], 8'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 400; k++) step(1'b0, 8'h00, 1'b0, 1'b0);

        // TICK_DIV 4 from 02: 01 after E4, 00 with done after E8.
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (k == 4) check("t4_e4", oc[2], 8'h01);
            if (k == 8) begin
                check("t4_e8_count", oc[2], 8'h00);
                check("t4_e8_done", 8'(odn[2]), 8'd1);
            end
        end

        // TICK_DIV 3 from 05 with a pause after four running edges.
        step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            check("t3_hold", oc[1], 8'h04);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (k == 10) check("t3_before_end", oc[1], 8'h01);
            if (k == 11) begin
                check("t3_end_count", oc[1], 8'h00);
                check("t3_end_done", 8'(odn[1]), 8'd1);
            end
        end

        // Start at 00 is ignored.
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("start_at_zero", 8'(orun[0]), 8'd0);

        // Load and pause together in RUN: load wins.
        step(1'b1, 8'h30, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b1);
        check("load_over_pause", 8'(orun[1]), 8'd0);

        // Randomized control traffic.
        for (int k = 0; k < 400; k++) begin
            step(logic'($urandom_range(0, 19) == 0), 8'($urandom),
                 logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-RUN from 50, then a start that must be ignored.
        step(1'b1, 8'h50, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
        async_reset_pulse();
        check("rst_count", oc[0], 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("rst_then_start", 8'(orun[2]), 8'd0);

        // Asynchronous reset cuts off a done pulse.
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_cut_done", 8'(odn[0]), 8'd1);
        async_reset_pulse();
        check("cut_done", 8'(odn[0]), 8'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
